// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/redirect controller with load-use, MDU and MEM waits
// Optional perf counters: define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic            id_rs1_ren,
  input  logic            id_rs2_ren,
  input  logic [4:0]      ex_rd_addr,
  input  logic            ex_rd_ena,
  input  logic            ex_load_flag,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_redirect_pc,
  input  logic            ex_mdu_start,
  input  logic            ex_mdu_done,
  input  logic            mem_req,
  input  logic            mem_ack,
  output logic            pc_stall,
  output logic            if_id_stall,
  output logic            id_ex_stall,
  output logic            ex_mem_stall,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            ex_mem_flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            hang_err,
  output logic [1:0]      state_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_lu_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2,
    REDIR    = 2'd3
  } state_t;

  state_t            state, state_next;
  logic              pend_valid;
  logic [XLEN-1:0]   pend_pc;
  logic [CNT_W-1:0]  wd_cnt;
  logic [CNT_W-1:0]  wd_inc;

  logic mem_wait, load_use, pend_take, lu_fire;
  logic s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, f_exmem, r_valid;
  logic [XLEN-1:0] r_pc;

  assign mem_wait = mem_req & ~mem_ack;
  assign load_use = ex_load_flag & ex_rd_ena & (ex_rd_addr != 5'd0) &
                    ((id_rs1_ren & (id_rs1_addr == ex_rd_addr)) |
                     (id_rs2_ren & (id_rs2_addr == ex_rd_addr)));

  // EX is frozen while memory stalls, so only the first redirect seen is genuine.
  assign pend_take = ex_redirect & ~pend_valid &
                     ((state == MEM_WAIT) | ((state == RUN) & mem_wait));

  assign wd_inc = (wd_cnt == {CNT_W{1'b1}}) ? wd_cnt : wd_cnt + 1'b1;

  always_comb begin
    state_next = state;
    s_pc       = 1'b0;
    s_ifid     = 1'b0;
    s_idex     = 1'b0;
    s_exmem    = 1'b0;
    f_ifid     = 1'b0;
    f_idex     = 1'b0;
    f_exmem    = 1'b0;
    r_valid    = 1'b0;
    r_pc       = '0;
    lu_fire    = 1'b0;
    case (state)
      RUN: begin
        if (mem_wait) begin
          {s_pc, s_ifid, s_idex, s_exmem} = 4'b1111;
          state_next = MEM_WAIT;
        end else if (ex_redirect) begin
          r_valid = 1'b1;
          r_pc    = ex_redirect_pc;
          f_ifid  = 1'b1;
          f_idex  = 1'b1;
        end else if (ex_mdu_start) begin
          state_next = MDU_WAIT;
        end else if (load_use) begin
          s_pc    = 1'b1;
          s_ifid  = 1'b1;
          f_idex  = 1'b1;
          lu_fire = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (ex_mdu_done) begin
          state_next = RUN;
        end else begin
          {s_pc, s_ifid, s_idex} = 3'b111;
          f_exmem = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_next = (pend_valid | pend_take) ? REDIR : RUN;
        end else begin
          {s_pc, s_ifid, s_idex, s_exmem} = 4'b1111;
        end
      end
      REDIR: begin
        r_valid    = 1'b1;
        r_pc       = pend_pc;
        f_ifid     = 1'b1;
        f_idex     = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // A register being zeroed must not also be held.
  always_comb begin
    pc_stall       = s_pc & ~rst;
    if_id_stall    = s_ifid & ~f_ifid & ~rst;
    id_ex_stall    = s_idex & ~f_idex & ~rst;
    ex_mem_stall   = s_exmem & ~f_exmem & ~rst;
    if_id_flush    = f_ifid & ~rst;
    id_ex_flush    = f_idex & ~rst;
    ex_mem_flush   = f_exmem & ~rst;
    redirect_valid = r_valid & ~rst;
    redirect_pc    = rst ? '0 : r_pc;
  end

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      wd_cnt     <= '0;
      hang_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == REDIR) begin
        pend_valid <= 1'b0;
        pend_pc    <= '0;
      end else if (pend_take) begin
        pend_valid <= 1'b1;
        pend_pc    <= ex_redirect_pc;
      end
      if ((state == MDU_WAIT) || (state == MEM_WAIT)) begin
        wd_cnt <= wd_inc;
        if (wd_inc >= CNT_W'(TIMEOUT))
          hang_err <= 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
      perf_lu_cnt    <= '0;
    end else begin
      if (pc_stall && (perf_stall_cyc != {CNT_W{1'b1}}))
        perf_stall_cyc <= perf_stall_cyc + 1'b1;
      if (redirect_valid && (perf_flush_cnt != {CNT_W{1'b1}}))
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
      if (lu_fire && (perf_lu_cnt != {CNT_W{1'b1}}))
        perf_lu_cnt <= perf_lu_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_rs1_ren, id_rs2_ren, ex_rd_ena, ex_load_flag, ex_redirect;
  logic [63:0] ex_redirect_pc;
  logic        ex_mdu_start, ex_mdu_done, mem_req, mem_ack;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, redirect_valid;
  logic [63:0] redirect_pc;
  logic        hang_err;
  logic [1:0]  state_o;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(64), .TIMEOUT(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
    .ex_rd_addr(ex_rd_addr), .ex_rd_ena(ex_rd_ena), .ex_load_flag(ex_load_flag),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .ex_mdu_start(ex_mdu_start), .ex_mdu_done(ex_mdu_done),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .hang_err(hang_err), .state_o(state_o)
  );

  // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, ex_mem_flush, redirect_valid}
  wire [7:0] outs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                     if_id_flush, id_ex_flush, ex_mem_flush, redirect_valid};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_ren = 0; id_rs2_ren = 0;
    ex_rd_addr = 0; ex_rd_ena = 0; ex_load_flag = 0; ex_redirect = 0;
    ex_redirect_pc = 0; ex_mdu_start = 0; ex_mdu_done = 0; mem_req = 0; mem_ack = 0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    #2;
    check("rst_outs", outs, 8'h00);
    check("rst_state", state_o, 2'd0);
    check("rst_hang", hang_err, 1'b0);
    check("rst_rpc", redirect_pc, 64'h0);
    rst = 1'b0;
    cyc();

    // load-use via rs2
    ex_load_flag = 1; ex_rd_addr = 5; ex_rd_ena = 1; id_rs2_addr = 5; id_rs2_ren = 1;
    #2; check("lu_rs2", outs, 8'b1100_0100);
    cyc(); idle(); #2;
    check("lu_one_cycle", outs, 8'h00);
    // x0 destination never hazards
    ex_load_flag = 1; ex_rd_addr = 0; ex_rd_ena = 1; id_rs2_addr = 0; id_rs2_ren = 1;
    #2; check("lu_x0", outs, 8'h00);
    // rs1 match without read enable
    ex_rd_addr = 7; id_rs1_addr = 7; id_rs1_ren = 0; id_rs2_ren = 0;
    #2; check("lu_noren", outs, 8'h00);
    id_rs1_ren = 1;
    #2; check("lu_rs1", outs, 8'b1100_0100);
    cyc(); idle();

    // redirect beats load-use and mdu start
    ex_load_flag = 1; ex_rd_addr = 5; ex_rd_ena = 1; id_rs2_addr = 5; id_rs2_ren = 1;
    ex_redirect = 1; ex_redirect_pc = 64'h8000_0040; ex_mdu_start = 1;
    #2;
    check("redir_outs", outs, 8'b0000_1101);
    check("redir_pc", redirect_pc, 64'h8000_0040);
    cyc(); idle(); #2;
    check("redir_no_mdu", state_o, 2'd0);

    // MDU wait of 5 cycles
    ex_mdu_start = 1;
    #2; check("mdu_start_outs", outs, 8'h00);
    cyc(); ex_mdu_start = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("mdu_state", state_o, 2'd1);
      check("mdu_outs", outs, 8'b1110_0010);
      cyc();
    end
    ex_mdu_done = 1;
    #2;
    check("mdu_done_state", state_o, 2'd1);
    check("mdu_done_outs", outs, 8'h00);
    cyc(); #2;
    check("mdu_back_run", state_o, 2'd0);
    cyc(); #2;
    check("mdu_done_ignored", state_o, 2'd0);
    idle();

    // MEM wait with redirect latched mid-wait
    mem_req = 1;
    #2; check("mem_c1", outs, 8'hF0);
    cyc();
    ex_redirect = 1; ex_redirect_pc = 64'h8000_1000;
    #2;
    check("mem_c2_state", state_o, 2'd2);
    check("mem_c2", outs, 8'hF0);
    cyc();
    ex_redirect_pc = 64'h8000_2000;
    #2; check("mem_c3", outs, 8'hF0);
    cyc();
    ex_redirect = 0; mem_ack = 1;
    #2;
    check("mem_ack_outs", outs, 8'h00);
    check("mem_ack_state", state_o, 2'd2);
    cyc(); idle(); #2;
    check("redir_state", state_o, 2'd3);
    check("redir_state_outs", outs, 8'b0000_1101);
    check("redir_state_pc", redirect_pc, 64'h8000_1000);
    cyc(); #2;
    check("after_redir", state_o, 2'd0);
    check("after_redir_outs", outs, 8'h00);

    // req and ack together: no stall
    mem_req = 1; mem_ack = 1;
    #2; check("mem_hit", outs, 8'h00);
    cyc(); #2;
    check("mem_hit_state", state_o, 2'd0);
    idle();

    // watchdog, TIMEOUT=8
    mem_req = 1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      #2;
      check("wd_hang", hang_err, (i >= 8) ? 1'b1 : 1'b0);
      cyc();
    end
    mem_ack = 1;
    cyc(); idle(); #2;
    check("wd_state", state_o, 2'd0);
    check("wd_sticky", hang_err, 1'b1);
    rst = 1;
    cyc(); rst = 0; #2;
    check("wd_cleared", hang_err, 1'b0);
    check("wd_rst_state", state_o, 2'd0);

    // reset aborts MDU wait
    ex_mdu_start = 1;
    cyc(); ex_mdu_start = 0; #2;
    check("mdu_pre_rst", state_o, 2'd1);
    rst = 1;
    cyc(); rst = 0; #2;
    check("mdu_rst_state", state_o, 2'd0);
    check("mdu_rst_outs", outs, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
